seq_chunk_adder: RTL



---
 rtl/seq_chunk_adder_if.sv | 39 +++
 rtl/seq_chunk_adder.sv | 119 +++++++++++
 2 files changed

// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: operand start/ready and result valid/ack bundle.
// master: drives i_start/i_x/i_y/i_carry/i_sub/i_ack and sees results;
// slave: the adder, drives o_ready/o_valid/o_sum/o_carry.
// With SEQ_CHUNK_ADDER_OVERFLOW_EN defined the bundle also carries o_overflow.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_x;
    logic [WIDTH-1:0] i_y;
    logic             i_carry;
    logic             i_sub;
    logic             o_ready;
    logic             o_valid;
    logic             i_ack;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
    logic             o_overflow;

    modport master (
        output i_start, i_x, i_y, i_carry, i_sub, i_ack,
        input  o_ready, o_valid, o_sum, o_carry, o_overflow
    );
    modport slave (
        input  i_start, i_x, i_y, i_carry, i_sub, i_ack,
        output o_ready, o_valid, o_sum, o_carry, o_overflow
    );
`else
    modport master (
        output i_start, i_x, i_y, i_carry, i_sub, i_ack,
        input  o_ready, o_valid, o_sum, o_carry
    );
    modport slave (
        input  i_start, i_x, i_y, i_carry, i_sub, i_ack,
        output o_ready, o_valid, o_sum, o_carry
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: adds/subtracts two WIDTH-bit operands CHUNK bits per clock.
// Ports: i_clk, i_rst (sync, active-high), bus (seq_chunk_adder_if.slave).
// Optional macro SEQ_CHUNK_ADDER_OVERFLOW_EN adds bus.o_overflow.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    seq_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             cr;
    logic             co_q;
    logic             ready_q;
    logic             valid_q;

    logic [CHUNK-1:0] xa;
    logic [CHUNK-1:0] ya;
    logic [CHUNK-1:0] s;
    logic             c;

    always_comb begin
        xa = '0;
        ya = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) begin
                xa = xr[k*CHUNK +: CHUNK];
                ya = yr[k*CHUNK +: CHUNK];
            end
        end
        {c, s} = {1'b0, xa} + {1'b0, ya} + {{CHUNK{1'b0}}, cr};
    end

`ifdef SEQ_CHUNK_ADDER_OVERFLOW_EN
    logic ov;
    logic ov_q;
    // Carry into the chunk MSB recovered from its sum bit.
    assign ov = (xa[CHUNK-1] ^ ya[CHUNK-1] ^ s[CHUNK-1]) ^ c;
    assign bus.o_overflow = ov_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ov_q <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            ov_q <= ov;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            cnt     <= '0;
            cr      <= 1'b0;
            xr      <= '0;
            yr      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        xr      <= bus.i_x;
                        // Subtract runs as x + ~y + ~borrow.
                        yr      <= bus.i_sub ? ~bus.i_y : bus.i_y;
                        cr      <= bus.i_sub ^ bus.i_carry;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (cnt == CW'(k)) begin
                            sum_q[k*CHUNK +: CHUNK] <= s;
                        end
                    end
                    cr  <= c;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        co_q    <= c;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ack) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = co_q;
endmodule
